// File: rtl/prim_asm_pkg.sv
// Shared defaults, mode encodings and slot helpers for the primitive assembler.
package prim_asm_pkg;

   localparam int unsigned DATA_W_DEFAULT = 96;
   localparam int unsigned VERTS_DEFAULT  = 3;

   localparam logic MODE_LIST  = 1'b0;
   localparam logic MODE_STRIP = 1'b1;

   // Bit offset of a slot inside a packed multi-vertex bus.
   function automatic int unsigned slot_lsb(input int unsigned idx, input int unsigned width);
      return idx * width;
   endfunction

endpackage

// File: rtl/prim_out_stage.sv
// Valid/ready holding register for assembled primitives, with strip winding swap
// and a count of primitives accepted downstream.
module prim_out_stage
   import prim_asm_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT,
   parameter int unsigned VERTS  = VERTS_DEFAULT,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic                    swap,
   input  logic [VERTS*DATA_W-1:0] vertex_in,
   input  logic [VERTS*DATA_W-1:0] color_in,
   output logic                    can_load,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic [VERTS*DATA_W-1:0] vertex_out,
   output logic [VERTS*DATA_W-1:0] color_out,
   output logic [CNT_W-1:0]        prim_count
);

   logic                    valid_q, valid_d;
   logic [VERTS*DATA_W-1:0] vertex_q, vertex_d, color_q, color_d;
   logic [VERTS*DATA_W-1:0] vertex_sw, color_sw;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    accept;

   // Odd strip triangles swap their first two vertices to keep a consistent winding.
   always_comb begin
      vertex_sw = vertex_in;
      color_sw  = color_in;
      if (swap) begin
         vertex_sw[slot_lsb(0, DATA_W) +: DATA_W] = vertex_in[slot_lsb(1, DATA_W) +: DATA_W];
         vertex_sw[slot_lsb(1, DATA_W) +: DATA_W] = vertex_in[slot_lsb(0, DATA_W) +: DATA_W];
         color_sw[slot_lsb(0, DATA_W) +: DATA_W]  = color_in[slot_lsb(1, DATA_W) +: DATA_W];
         color_sw[slot_lsb(1, DATA_W) +: DATA_W]  = color_in[slot_lsb(0, DATA_W) +: DATA_W];
      end
   end

   always_comb begin
      accept   = valid_q && out_ready;
      valid_d  = valid_q;
      vertex_d = vertex_q;
      color_d  = color_q;
      count_d  = count_q + CNT_W'(accept);
      if (accept) begin
         valid_d = 1'b0;
      end
      if (load) begin
         valid_d  = 1'b1;
         vertex_d = vertex_sw;
         color_d  = color_sw;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= 1'b0;
         vertex_q <= '0;
         color_q  <= '0;
         count_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         vertex_q <= vertex_d;
         color_q  <= color_d;
         count_q  <= count_d;
      end
   end

   assign can_load   = !valid_q || out_ready;
   assign out_valid  = valid_q;
   assign vertex_out = vertex_q;
   assign color_out  = color_q;
   assign prim_count = count_q;

endmodule

// File: rtl/prim_assembler.sv
// Pops paired vertex/color words from two FIFOs and assembles VERTS-vertex primitives
// in list or strip order, handing them to a valid/ready output stage.
module prim_assembler
   import prim_asm_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT,
   parameter int unsigned VERTS  = VERTS_DEFAULT,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    vertex_empty,
   input  logic                    color_empty,
   input  logic [DATA_W-1:0]       vertex_in,
   input  logic [DATA_W-1:0]       color_in,
   output logic                    vertex_rd_en,
   output logic                    color_rd_en,
   input  logic                    strip_mode,
   input  logic                    strip_restart,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [VERTS*DATA_W-1:0] vertex_out,
   output logic [VERTS*DATA_W-1:0] color_out,
   output logic [CNT_W-1:0]        prim_count
);

   localparam int unsigned FW = $clog2(VERTS + 1);
   localparam int unsigned SW = FW + 1;

   logic [VERTS-1:0][DATA_W-1:0] vslot_q, vslot_d, cslot_q, cslot_d;
   logic [FW-1:0]                filled_q, filled_d;
   logic                         rd_en_q, rd_en_d;
   logic                         pending_q;
   logic                         parity_q, parity_d;
   logic                         mode_q, mode_d;
   logic                         can_load, transfer, idle, swap;

   always_comb begin
      transfer = (filled_q == FW'(VERTS)) && can_load;
      idle     = (filled_q == '0) && !rd_en_q && !pending_q;
      vslot_d  = vslot_q;
      cslot_d  = cslot_q;
      filled_d = filled_q;
      parity_d = parity_q;
      mode_d   = mode_q;

      if (transfer) begin
         if (mode_q == MODE_LIST) begin
            filled_d = '0;
         end else begin
            for (int unsigned i = 0; i + 1 < VERTS; i++) begin
               vslot_d[i] = vslot_q[i+1];
               cslot_d[i] = cslot_q[i+1];
            end
            filled_d = FW'(VERTS - 1);
            parity_d = !parity_q;
         end
      end

      // Read issue guarantees a capture never lands on a full collector.
      if (pending_q) begin
         for (int unsigned i = 0; i < VERTS; i++) begin
            if (filled_q == FW'(i)) begin
               vslot_d[i] = vertex_in;
               cslot_d[i] = color_in;
            end
         end
         filled_d = filled_q + 1'b1;
      end

      if (strip_restart) begin
         parity_d = 1'b0;
         filled_d = '0;
         if (pending_q) begin
            vslot_d[0] = vertex_in;
            cslot_d[0] = color_in;
            filled_d   = FW'(1);
         end
      end

      if (idle) begin
         mode_d = strip_mode;
      end

      // filled_d already includes this cycle's capture; rd_en_q is the read still in flight.
      rd_en_d = !vertex_empty && !color_empty && !strip_restart &&
                ((SW'(filled_d) + SW'(rd_en_q)) < SW'(VERTS));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vslot_q   <= '0;
         cslot_q   <= '0;
         filled_q  <= '0;
         rd_en_q   <= 1'b0;
         pending_q <= 1'b0;
         parity_q  <= 1'b0;
         mode_q    <= MODE_LIST;
      end else begin
         vslot_q   <= vslot_d;
         cslot_q   <= cslot_d;
         filled_q  <= filled_d;
         rd_en_q   <= rd_en_d;
         pending_q <= rd_en_q;
         parity_q  <= parity_d;
         mode_q    <= mode_d;
      end
   end

   assign swap         = (mode_q == MODE_STRIP) && parity_q;
   assign vertex_rd_en = rd_en_q;
   assign color_rd_en  = rd_en_q;

   prim_out_stage #(
      .DATA_W (DATA_W),
      .VERTS  (VERTS),
      .CNT_W  (CNT_W)
   ) u_out_stage (
      .clk        (clk),
      .rst        (rst),
      .load       (transfer),
      .swap       (swap),
      .vertex_in  (vslot_q),
      .color_in   (cslot_q),
      .can_load   (can_load),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .vertex_out (vertex_out),
      .color_out  (color_out),
      .prim_count (prim_count)
   );

endmodule

// File: tb/tb_prim_assembler.sv
// Directed bench for prim_assembler: table of list/strip runs plus hand-written
// sequences for latency, backpressure, empty FIFOs, strip restart and async reset.
module tb_prim_assembler;

   localparam int unsigned DW = 96;
   localparam int unsigned NV = 3;
   localparam int unsigned CW = 16;
   localparam int unsigned PW = NV * DW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          vertex_empty, color_empty;
   logic [DW-1:0] vertex_in = '0;
   logic [DW-1:0] color_in = '0;
   logic          vertex_rd_en, color_rd_en;
   logic          strip_mode = 1'b0;
   logic          strip_restart = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [PW-1:0] vertex_out, color_out;
   logic [CW-1:0] prim_count;

   typedef struct {
      logic [PW-1:0] v;
      logic [PW-1:0] c;
   } prim_t;

   typedef struct {
      string       name;
      logic        strip;
      int          first;
      int          nwords;
      int          nprims;
      logic [71:0] exp;  // byte k = vertex word of prim k/3, slot k%3
   } vec_t;

   prim_t         got[$];
   int            rd_log[$];
   int            cyc = 0;
   int            valid_cyc = -1;
   int            n_checks = 0;
   int            n_fail = 0;
   logic [DW-1:0] vmem[64];
   logic [DW-1:0] cmem[64];
   int            wr = 0;
   int            rd = 0;
   logic          v_hold = 1'b0;
   logic          c_hold = 1'b0;
   vec_t          tbl[4];

   assign vertex_empty = (rd == wr) || v_hold;
   assign color_empty  = (rd == wr) || c_hold;

   prim_assembler #(
      .DATA_W (DW),
      .VERTS  (NV),
      .CNT_W  (CW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .vertex_empty  (vertex_empty),
      .color_empty   (color_empty),
      .vertex_in     (vertex_in),
      .color_in      (color_in),
      .vertex_rd_en  (vertex_rd_en),
      .color_rd_en   (color_rd_en),
      .strip_mode    (strip_mode),
      .strip_restart (strip_restart),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .vertex_out    (vertex_out),
      .color_out     (color_out),
      .prim_count    (prim_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Standard-read FIFO model: data appears the cycle after the pop.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rd <= wr;
      end else if (vertex_rd_en) begin
         vertex_in <= vmem[rd[5:0]];
         color_in  <= cmem[rd[5:0]];
         rd        <= rd + 1;
      end
   end

   task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) check("rd_en_pair", PW'(color_rd_en), PW'(vertex_rd_en));
      if (vertex_rd_en) rd_log.push_back(cyc);
      if (out_valid && valid_cyc < 0) valid_cyc = cyc;
      if (out_valid && out_ready) got.push_back('{v: vertex_out, c: color_out});
   end

   function automatic logic [PW-1:0] pack3(input int a, input int b, input int c);
      return {DW'(c), DW'(b), DW'(a)};
   endfunction

   function automatic vec_t mk(input string n, input logic s, input int f, input int nw,
                               input int np, input logic [71:0] e);
      vec_t r;
      r.name = n; r.strip = s; r.first = f; r.nwords = nw; r.nprims = np; r.exp = e;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int w);
      vmem[wr[5:0]] = DW'(w);
      cmem[wr[5:0]] = DW'(w + 256);
      wr = wr + 1;
   endtask

   task automatic do_reset(input logic strip);
      tick();
      rst = 1'b1;
      strip_mode = strip;
      out_ready = 1'b0;
      strip_restart = 1'b0;
      v_hold = 1'b0;
      c_hold = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      got.delete();
      rd_log.delete();
      valid_cyc = -1;
   endtask

   task automatic wait_prims(input int n, input string name);
      int k = 0;
      while (got.size() < n && k < 400) begin
         tick();
         k++;
      end
      check({name, "_timeout"}, PW'(got.size() >= n), PW'(1));
   endtask

   task automatic check_prim(input string name, input int idx, input int a, input int b,
                             input int c);
      if (idx < got.size()) begin
         check({name, "_vtx"}, got[idx].v, pack3(a, b, c));
         check({name, "_col"}, got[idx].c, pack3(a + 256, b + 256, c + 256));
      end else begin
         check({name, "_missing"}, PW'(got.size()), PW'(idx + 1));
      end
   endtask

   initial begin
      int r0, r1, r2, k;

      tbl[0] = mk("list_1_6",   1'b0, 1,  6, 2, 72'h00_00_00_06_05_04_03_02_01);
      tbl[1] = mk("strip_1_5",  1'b1, 1,  5, 3, 72'h05_04_03_04_02_03_03_02_01);
      tbl[2] = mk("strip_1_4",  1'b1, 1,  4, 2, 72'h00_00_00_04_02_03_03_02_01);
      tbl[3] = mk("list_10_12", 1'b0, 10, 3, 1, 72'h00_00_00_00_00_00_0c_0b_0a);

      do_reset(1'b0);
      check("rst_valid", PW'(out_valid), PW'(0));
      check("rst_rd_en", PW'(vertex_rd_en), PW'(0));
      check("rst_count", PW'(prim_count), PW'(0));
      check("rst_vertex_out", vertex_out, PW'(0));
      check("rst_color_out", color_out, PW'(0));

      for (int t = 0; t < 4; t++) begin
         do_reset(tbl[t].strip);
         out_ready = 1'b1;
         for (int w = 0; w < tbl[t].nwords; w++) push(tbl[t].first + w);
         wait_prims(tbl[t].nprims, tbl[t].name);
         repeat (10) tick();
         check({tbl[t].name, "_nprims"}, PW'(got.size()), PW'(tbl[t].nprims));
         check({tbl[t].name, "_prim_count"}, PW'(prim_count), PW'(tbl[t].nprims));
         for (int p = 0; p < tbl[t].nprims; p++) begin
            check_prim($sformatf("%s_p%0d", tbl[t].name, p), p,
                       int'(tbl[t].exp[(p*3+0)*8 +: 8]), int'(tbl[t].exp[(p*3+1)*8 +: 8]),
                       int'(tbl[t].exp[(p*3+2)*8 +: 8]));
         end
      end

      // Read pattern and first-output latency.
      do_reset(1'b0);
      out_ready = 1'b1;
      for (int w = 1; w <= 3; w++) push(w);
      wait_prims(1, "lat");
      repeat (5) tick();
      r0 = -100; r1 = -100; r2 = -100;
      if (rd_log.size() >= 3) begin
         r0 = rd_log[0]; r1 = rd_log[1]; r2 = rd_log[2];
      end
      check("lat_rd_count", PW'(rd_log.size()), PW'(3));
      check("lat_rd_consecutive", PW'((r1 == r0 + 1) && (r2 == r1 + 1)), PW'(1));
      check("lat_first_valid", PW'(valid_cyc), PW'(r2 + 3));
      check_prim("lat_p0", 0, 1, 2, 3);

      // Backpressure: output held, collector fills, reads stop, then resume.
      do_reset(1'b0);
      for (int w = 1; w <= 9; w++) push(w);
      k = 0;
      while (!out_valid && k < 100) begin
         tick();
         k++;
      end
      check("bp_valid_timeout", PW'(out_valid), PW'(1));
      repeat (15) tick();
      check("bp_hold_valid", PW'(out_valid), PW'(1));
      check("bp_hold_data", vertex_out, pack3(1, 2, 3));
      check("bp_reads_stopped", PW'(rd_log.size()), PW'(6));
      check("bp_rd_en_low", PW'(vertex_rd_en), PW'(0));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_next_valid", PW'(out_valid), PW'(1));
      check("bp_next_data", vertex_out, pack3(4, 5, 6));
      check("bp_next_count", PW'(prim_count), PW'(1));
      check("bp_reads_resume", PW'(vertex_rd_en), PW'(1));
      repeat (10) tick();
      out_ready = 1'b1;
      wait_prims(3, "bp");
      check_prim("bp_p1", 1, 4, 5, 6);
      check_prim("bp_p2", 2, 7, 8, 9);
      check("bp_count", PW'(prim_count), PW'(3));

      // One FIFO empty: no reads until both have data.
      do_reset(1'b0);
      out_ready = 1'b1;
      c_hold = 1'b1;
      for (int w = 1; w <= 3; w++) push(w);
      repeat (20) tick();
      check("empty_no_reads", PW'(rd_log.size()), PW'(0));
      c_hold = 1'b0;
      tick();
      check("empty_vrd_start", PW'(vertex_rd_en), PW'(1));
      check("empty_crd_start", PW'(color_rd_en), PW'(1));
      wait_prims(1, "empty");
      check_prim("empty_p0", 0, 1, 2, 3);

      // Strip restart discards the partial strip and clears parity.
      do_reset(1'b1);
      out_ready = 1'b1;
      for (int w = 1; w <= 4; w++) push(w);
      wait_prims(2, "restart_pre");
      repeat (5) tick();
      strip_restart = 1'b1;
      tick();
      strip_restart = 1'b0;
      for (int w = 10; w <= 13; w++) push(w);
      wait_prims(4, "restart");
      repeat (10) tick();
      check("restart_nprims", PW'(got.size()), PW'(4));
      check_prim("restart_p2", 2, 10, 11, 12);
      check_prim("restart_p3", 3, 12, 11, 13);
      check("restart_count", PW'(prim_count), PW'(4));

      // Async reset mid-cycle with a held output and a partial collector.
      do_reset(1'b0);
      out_ready = 1'b1;
      for (int w = 1; w <= 3; w++) push(w);
      wait_prims(1, "arst_pre");
      out_ready = 1'b0;
      for (int w = 4; w <= 6; w++) push(w);
      repeat (10) tick();
      for (int w = 20; w <= 21; w++) push(w);
      repeat (8) tick();
      check("arst_pre_valid", PW'(out_valid), PW'(1));
      check("arst_pre_count", PW'(prim_count), PW'(1));
      #3;
      rst = 1'b1;
      #1;
      check("arst_valid", PW'(out_valid), PW'(0));
      check("arst_rd_en", PW'(vertex_rd_en), PW'(0));
      check("arst_count", PW'(prim_count), PW'(0));
      check("arst_vertex_out", vertex_out, PW'(0));
      tick();
      rst = 1'b0;
      got.delete();
      out_ready = 1'b1;
      for (int w = 7; w <= 9; w++) push(w);
      wait_prims(1, "arst");
      repeat (5) tick();
      check_prim("arst_p0", 0, 7, 8, 9);
      check("arst_count_after", PW'(prim_count), PW'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/prim_assembler.md
Name: prim_assembler

Overview:
- Parametrised successor to the rasterizer's fixed three-vertex input register.
- Pops paired vertex/color words from two standard-read FIFOs (1-cycle read latency) and assembles VERTS-vertex primitives.
- Presents each primitive on a valid/ready output holding stage, so the next primitive is collected while the current one is stalled.
- Supports list mode and strip mode (vertex reuse with winding correction). Sits between the vertex/color FIFOs and the rasterizer setup stage.

Parameters:
- DATA_W, 96, width of one vertex word and one color word.
- VERTS, 3, vertices per primitive; legal range 2..8. Strip mode requires VERTS>=3.
- CNT_W, 16, width of prim_count.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- vertex_empty  in  1  vertex FIFO empty.
- color_empty  in  1  color FIFO empty.
- vertex_in  in  DATA_W  vertex FIFO read data; valid the cycle after vertex_rd_en.
- color_in  in  DATA_W  color FIFO read data; valid the cycle after color_rd_en.
- vertex_rd_en  out  1  vertex FIFO pop, registered.
- color_rd_en  out  1  color FIFO pop, registered; always equal to vertex_rd_en.
- strip_mode  in  1  0 = list, 1 = strip; sampled only when idle.
- strip_restart  in  1  single-cycle pulse that discards the partial primitive and resets strip parity.
- out_valid  out  1  primitive available.
- out_ready  in  1  consumer accepts the primitive when out_valid && out_ready.
- vertex_out  out  VERTS*DATA_W  slot i at bits [i*DATA_W +: DATA_W].
- color_out  out  VERTS*DATA_W  same packing as vertex_out.
- prim_count  out  CNT_W  primitives accepted by the consumer; wraps.

Behaviour:
- Reset (async, rst=1): vertex_rd_en=color_rd_en=0, out_valid=0, vertex_out=color_out=0, prim_count=0. Internal state also clears: filled=0, pending=0, parity=0, mode_q=0. Read data in flight at reset is discarded.
- Collector holds VERTS slots plus counters filled (0..VERTS) and pending (0..1 reads outstanding). Invariant: filled+pending <= VERTS.
- Read issue:
  - rd_en<=1 when !vertex_empty && !color_empty && (filled+pending) < VERTS && !strip_restart; otherwise rd_en<=0.
  - Back-to-back reads are allowed, giving 1 vertex/cycle.
  - The two FIFOs are never popped independently.
- Capture: the cycle after rd_en, vertex_in/color_in are written to slot[filled] and filled increments.
- Transfer:
  - Condition: filled==VERTS && (!out_valid || out_ready).
  - Collector copies to vertex_out/color_out and out_valid<=1.
  - List mode: filled<=0.
  - Strip mode: slots shift down by one (slot[i]<=slot[i+1]), filled<=VERTS-1, parity toggles.
- Winding: in strip mode, when parity==1 at transfer, slots 0 and 1 are swapped in the output copy only.
- Output stage:
  - Accept (out_valid && out_ready && no transfer): out_valid<=0.
  - Accept and transfer in the same cycle: out_valid stays 1 with new data.
  - prim_count increments on every accept.
  - vertex_out/color_out are stable while out_valid && !out_ready.
- Latency: with the third rd_en high in cycle t, data arrives in t+1, filled==VERTS in t+2, out_valid high in t+3.
- mode_q<=strip_mode only when filled==0 && pending==0. Changes at other times are ignored until idle.
- strip_restart:
  - Sets filled<=0 and parity<=0.
  - If a capture lands in the same cycle, that word goes to slot 0 and filled<=1.
  - Does not affect the output stage.
  - Suppresses rd_en for that cycle.
- A full collector with a stalled output produces no reads; FIFOs back up naturally.
- Empty FIFOs: no reads. The collector retains its partial contents indefinitely.

Decomposition:
- Package prim_asm_pkg: DATA_W/VERTS defaults, MODE_LIST=0/MODE_STRIP=1 constants, slot-index helper function.
- One sub-module: prim_out_stage, the valid/ready holding register with winding swap and prim_count.
- Collector and read-issue logic stay in prim_assembler.

Test Plan:
- List, VERTS=3, FIFOs preloaded with vertex/color words 1..6, out_ready=1 -> primitives (1,2,3) then (4,5,6); rd_en high 3 consecutive cycles per primitive; first out_valid 3 cycles after third rd_en; prim_count=2.
- Backpressure: out_ready=0 after first out_valid, 9 words queued -> output holds (1,2,3) unchanged; words 4,5,6 collected, then rd_en stays 0. out_ready=1 for one cycle -> (4,5,6) presented next cycle and reads resume.
- Strip, words 1..5 -> outputs (1,2,3), (3,2,4), (3,4,5); prim_count=3.
- Strip, words 1..4 consumed, strip_restart pulsed, then words 10,11,12 -> next output (10,11,12) with parity 0 (no swap).
- vertex_empty=0, color_empty=1 for 20 cycles -> rd_en never asserts. color_empty->0 -> paired reads start next cycle.
- Async rst asserted mid-cycle after 2 words captured -> out_valid, rd_en, prim_count drop to 0 immediately. After release, words 7,8,9 -> output (7,8,9).
